// File: rtl/risc_dmem_responder.sv
// Data-memory responder: accepts one load/store, inserts WAIT_CYCLES wait states, then pulses ack.
// Optional feature macro: DMEM_PARITY_EN (17th even-parity bit per word, inj_err input, perr output).
module risc_dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
`ifdef DMEM_PARITY_EN
  input  logic              inj_err,
  output logic              perr,
`endif
  output logic [15:0]       rdata,
  output logic              ack,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef DMEM_PARITY_EN
  localparam int WORD_W = 17;
`else
  localparam int WORD_W = 16;
`endif
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [15:0]         wdata_reg;
  logic                rd_valid_reg;
  logic [WORD_W-1:0]   rd_word_reg;
  logic [WORD_W-1:0]   wr_word;
  logic                capture;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic                rd_en;
  logic                wr_en;

  logic [WORD_W-1:0]   mem [DEPTH];

  // Next-state and wait-state counting; inputs are only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          cnt_next   = 4'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // With zero wait states the read happens on the acceptance edge, so bypass the capture regs.
  always_comb begin
    cur_we   = capture ? we : we_reg;
    cur_addr = capture ? addr : addr_reg;
    rd_en    = (state_next == RESP) && !cur_we;
    wr_en    = (state_reg == RESP) && we_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 16'h0000;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        we_reg    <= we;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
      if (rd_en) begin
        rd_valid_reg <= 1'b1;
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic inj_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_reg <= 1'b0;
    end else if (capture) begin
      inj_reg <= inj_err;
    end
  end

  assign wr_word = {(^wdata_reg) ^ inj_reg, wdata_reg};
  assign perr    = (state_reg == RESP) && !we_reg && ((^rd_word_reg[15:0]) != rd_word_reg[16]);
`else
  assign wr_word = wdata_reg;
`endif

  // Memory is never reset; a read and a write can never fall on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_reg] <= wr_word;
    end
    if (rd_en) begin
      rd_word_reg <= mem[cur_addr];
    end
  end

  assign rdata = rd_valid_reg ? rd_word_reg[15:0] : 16'h0000;
  assign ack   = (state_reg == RESP);
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_risc_dmem_responder.sv
// Directed bench for risc_dmem_responder: one instance with 2 wait states, one with none.
// Parity checks are compiled in when DMEM_PARITY_EN is defined.
module tb_risc_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_a, we_a, ack_a, busy_a;
  logic [7:0]  addr_a;
  logic [15:0] wdata_a, rdata_a;
  logic        req_b, we_b, ack_b, busy_b;
  logic [7:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;
`ifdef DMEM_PARITY_EN
  logic        inj_a, perr_a, inj_b, perr_b;
  logic        pe_last;
`endif

  int checks = 0;
  int errors = 0;

  risc_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
`ifdef DMEM_PARITY_EN
    .inj_err(inj_a), .perr(perr_a),
`endif
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a)
  );

  risc_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
`ifdef DMEM_PARITY_EN
    .inj_err(inj_b), .perr(perr_b),
`endif
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s observed=%h expected=%h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the 2-wait-state instance; n = cycles from acceptance edge to ack.
  task automatic txn_a(input logic w, input logic [7:0] a, input logic [15:0] d, input bit scramble,
                       output int n, output logic [15:0] rd, output logic bz);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        addr_a = 8'h00; wdata_a = 16'h0000;
      end
    end while (!ack_a && n < 20);
    rd = rdata_a;
    bz = busy_a;
`ifdef DMEM_PARITY_EN
    pe_last = perr_a;
`endif
    req_a = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int acks;
    logic [15:0] rd;
    logic bz;

    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 16'h0000;
    req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 16'h0000;
`ifdef DMEM_PARITY_EN
    inj_a = 1'b0; inj_b = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    chk("reset_rdata", rdata_a, 16'h0000);
    chk("reset_ack", ack_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Store then load at 0x10.
    txn_a(1'b1, 8'h10, 16'hBEEF, 1'b0, n, rd, bz);
    chk("store_latency", n, 3);
    chk("store_busy_in_ack", bz, 1'b1);
    chk("store_ack_after", ack_a, 1'b0);
    chk("store_busy_after", busy_a, 1'b0);
    txn_a(1'b0, 8'h10, 16'h0000, 1'b0, n, rd, bz);
    chk("load_latency", n, 3);
    chk("load_rdata_10", rd, 16'hBEEF);
    chk("load_rdata_hold", rdata_a, 16'hBEEF);

    // Inputs changed during WAIT must not affect the captured store.
    txn_a(1'b1, 8'h00, 16'h5A5A, 1'b0, n, rd, bz);
    txn_a(1'b1, 8'h20, 16'hA5A5, 1'b1, n, rd, bz);
    chk("store_scrambled_latency", n, 3);
    chk("rdata_hold_over_store", rdata_a, 16'hBEEF);
    txn_a(1'b0, 8'h20, 16'h0000, 1'b0, n, rd, bz);
    chk("load_rdata_20", rd, 16'hA5A5);
    txn_a(1'b0, 8'h00, 16'h0000, 1'b0, n, rd, bz);
    chk("load_rdata_00", rd, 16'h5A5A);

    // Back-to-back read-after-write.
    txn_a(1'b1, 8'h30, 16'hC0DE, 1'b0, n, rd, bz);
    txn_a(1'b0, 8'h30, 16'h0000, 1'b0, n, rd, bz);
    chk("raw_rdata_30", rd, 16'hC0DE);

    // Aborted store to the top address.
    txn_a(1'b1, 8'hFF, 16'h7777, 1'b0, n, rd, bz);
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'hFF; wdata_a = 16'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", busy_a, 1'b1);
    reset = 1'b0;
    req_a = 1'b0;
    #1;
    chk("abort_rdata_in_reset", rdata_a, 16'h0000);
    chk("abort_busy_in_reset", busy_a, 1'b0);
    chk("abort_ack_in_reset", ack_a, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack_a) acks++;
    end
    chk("abort_no_ack", acks, 0);
    txn_a(1'b0, 8'hFF, 16'h0000, 1'b0, n, rd, bz);
    chk("abort_mem_kept_ff", rd, 16'h7777);

    // Zero wait states with req held for four transactions.
    req_b = 1'b1; we_b = 1'b1; addr_b = 8'h05; wdata_b = 16'h0042;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack_c%0d", k), ack_b, 1'((k % 2) == 1));
      chk($sformatf("b2b_busy_c%0d", k), busy_b, 1'((k % 2) == 1));
      if (k == 7) req_b = 1'b0;
    end
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'h05;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_b && n < 20);
    chk("b_load_latency", n, 1);
    chk("b_load_rdata_05", rdata_b, 16'h0042);
    req_b = 1'b0;
    @(posedge clk); #1;
    chk("b_ack_after", ack_b, 1'b0);

`ifdef DMEM_PARITY_EN
    inj_a = 1'b1;
    txn_a(1'b1, 8'h40, 16'h0001, 1'b0, n, rd, bz);
    inj_a = 1'b0;
    txn_a(1'b0, 8'h40, 16'h0000, 1'b0, n, rd, bz);
    chk("parity_err_injected", pe_last, 1'b1);
    chk("parity_rdata", rd, 16'h0001);
    chk("parity_low_after_ack", perr_a, 1'b0);
    txn_a(1'b1, 8'h40, 16'h0001, 1'b0, n, rd, bz);
    txn_a(1'b0, 8'h40, 16'h0000, 1'b0, n, rd, bz);
    chk("parity_clean", pe_last, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
